// File: rtl/ibex_msg_fifo.sv
// In-order message buffer between a producer core's message port and a consumer core's input.
// Optional occupancy statistics (drop counter, high-water mark) under IBEX_MSG_FIFO_STATS_EN.
module ibex_msg_fifo #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_valid_i,
  input  logic [AddrWidth-1:0]       push_addr_i,
  input  logic [1:0]                 push_len_i,
  input  logic [31:0]                push_data_i,
  input  logic [31:0]                push_msg1_i,
  input  logic [31:0]                push_msg2_i,
  input  logic [31:0]                push_msg3_i,
  output logic                       pop_valid_o,
  input  logic                       pop_ready_i,
  output logic [AddrWidth-1:0]       pop_addr_o,
  output logic [1:0]                 pop_len_o,
  output logic [31:0]                pop_data_o,
  output logic [31:0]                pop_msg1_o,
  output logic [31:0]                pop_msg2_o,
  output logic [31:0]                pop_msg3_o,
  input  logic                       clear_i,
`ifdef IBEX_MSG_FIFO_STATS_EN
  output logic [15:0]                drop_cnt_o,
  output logic [$clog2(Depth):0]     hwm_o,
`endif
  output logic [$clog2(Depth):0]     count_o,
  output logic                       full_o,
  output logic                       overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [1:0]           len;
    logic [31:0]          data;
    logic [31:0]          msg1;
    logic [31:0]          msg2;
    logic [31:0]          msg3;
  } entry_t;

  entry_t            mem_q [Depth];
  entry_t            push_entry, head;
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              full, pop_fire, push_fire, drop;

  assign full      = (count_q == CntW'(Depth));
  assign pop_fire  = pop_valid_o & pop_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_fire = push_valid_i & (~full | pop_fire) & ~clear_i;
  assign drop      = push_valid_i & full & ~pop_fire & ~clear_i;

  assign push_entry = '{addr: push_addr_i, len: push_len_i, data: push_data_i,
                        msg1: push_msg1_i, msg2: push_msg2_i, msg3: push_msg3_i};

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push_fire) wptr_d = wptr_q + PtrW'(1);
      if (pop_fire)  rptr_d = rptr_q + PtrW'(1);
      if (push_fire && !pop_fire)      count_d = count_q + CntW'(1);
      else if (pop_fire && !push_fire) count_d = count_q - CntW'(1);
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage is not reset; the pointers alone define what is live.
  always_ff @(posedge clk_i) begin
    if (push_fire) mem_q[wptr_q] <= push_entry;
  end

  assign head        = mem_q[rptr_q];
  assign pop_valid_o = (count_q != '0);

  // Outputs are zeroed when empty so reset and flush present a clean idle bus.
  always_comb begin
    pop_addr_o = '0;
    pop_len_o  = '0;
    pop_data_o = '0;
    pop_msg1_o = '0;
    pop_msg2_o = '0;
    pop_msg3_o = '0;
    if (pop_valid_o) begin
      pop_addr_o = head.addr;
      pop_len_o  = head.len;
      pop_data_o = head.data;
      pop_msg1_o = (head.len >= 2'd1) ? head.msg1 : '0;
      pop_msg2_o = (head.len >= 2'd2) ? head.msg2 : '0;
      pop_msg3_o = (head.len == 2'd3) ? head.msg3 : '0;
    end
  end

  assign count_o    = count_q;
  assign full_o     = full;
  assign overflow_o = ovf_q;

`ifdef IBEX_MSG_FIFO_STATS_EN
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0] hwm_q, hwm_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    hwm_d      = hwm_q;
    if (clear_i) begin
      drop_cnt_d = '0;
      hwm_d      = '0;
    end else begin
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      // Track the post-edge occupancy so the mark is visible the same cycle as count_o.
      if (count_d > hwm_q) hwm_d = count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
      hwm_q      <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      hwm_q      <= hwm_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign hwm_o      = hwm_q;
`endif

endmodule

// File: tb/tb_ibex_msg_fifo.sv
// Directed bench for ibex_msg_fifo: queue-based reference model checked every cycle,
// plus literal expectations for the scenarios of interest.
module tb_ibex_msg_fifo;
  localparam int D  = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push_valid;
  logic [AW-1:0] push_addr;
  logic [1:0]    push_len;
  logic [31:0]   push_data, push_msg1, push_msg2, push_msg3;
  logic          pop_valid, pop_ready;
  logic [AW-1:0] pop_addr;
  logic [1:0]    pop_len;
  logic [31:0]   pop_data, pop_msg1, pop_msg2, pop_msg3;
  logic          clear;
  logic [2:0]    count;
  logic          full, overflow;
`ifdef IBEX_MSG_FIFO_STATS_EN
  logic [15:0]   drop_cnt;
  logic [2:0]    hwm;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ibex_msg_fifo #(.Depth(D), .AddrWidth(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .push_valid_i(push_valid), .push_addr_i(push_addr), .push_len_i(push_len),
    .push_data_i(push_data), .push_msg1_i(push_msg1), .push_msg2_i(push_msg2),
    .push_msg3_i(push_msg3),
    .pop_valid_o(pop_valid), .pop_ready_i(pop_ready), .pop_addr_o(pop_addr),
    .pop_len_o(pop_len), .pop_data_o(pop_data), .pop_msg1_o(pop_msg1),
    .pop_msg2_o(pop_msg2), .pop_msg3_o(pop_msg3),
    .clear_i(clear),
`ifdef IBEX_MSG_FIFO_STATS_EN
    .drop_cnt_o(drop_cnt), .hwm_o(hwm),
`endif
    .count_o(count), .full_o(full), .overflow_o(overflow)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    len;
    logic [31:0]   d, m1, m2, m3;
  } ent_t;

  ent_t m_q[$];
  bit   m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of messages updated from the rules at each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else if (clear) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      bit pf;
      pf = (m_q.size() != 0) && pop_ready;
      if (push_valid && !(m_q.size() < D || pf)) m_ovf = 1'b1;
      if (pf) void'(m_q.pop_front());
      if (push_valid && (m_q.size() < D))
        m_q.push_back('{push_addr, push_len, push_data, push_msg1, push_msg2, push_msg3});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_count", 32'(count), 32'(m_q.size()));
      check("m_full", 32'(full), 32'(m_q.size() == D));
      check("m_ovf", 32'(overflow), 32'(m_ovf));
      check("m_valid", 32'(pop_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check("m_addr", 32'(pop_addr), 32'(m_q[0].addr));
        check("m_len", 32'(pop_len), 32'(m_q[0].len));
        check("m_data", pop_data, m_q[0].d);
        check("m_msg1", pop_msg1, (m_q[0].len >= 1) ? m_q[0].m1 : 32'h0);
        check("m_msg2", pop_msg2, (m_q[0].len >= 2) ? m_q[0].m2 : 32'h0);
        check("m_msg3", pop_msg3, (m_q[0].len >= 3) ? m_q[0].m3 : 32'h0);
      end
    end
  end

  task automatic push_one(input logic [31:0] d, input logic [1:0] len);
    push_valid = 1'b1; push_addr = d[4:0] ^ 5'h15; push_len = len;
    push_data = d; push_msg1 = d + 32'h100; push_msg2 = d + 32'h200; push_msg3 = d + 32'h300;
    @(posedge clk); #1;
    push_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; push_valid = 0; push_addr = 0; push_len = 0; push_data = 0;
    push_msg1 = 0; push_msg2 = 0; push_msg3 = 0; pop_ready = 0; clear = 0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(pop_valid), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_data", pop_data, 0);

    // Single message, len=2 masks msg3.
    push_valid = 1; push_addr = 5'h03; push_len = 2; push_data = 32'hA5A5_0001;
    push_msg1 = 32'h11; push_msg2 = 32'h22; push_msg3 = 32'h33;
    @(posedge clk); #1; push_valid = 0;
    @(negedge clk);
    check("t1_valid", 32'(pop_valid), 1);
    check("t1_addr", 32'(pop_addr), 32'h03);
    check("t1_data", pop_data, 32'hA5A5_0001);
    check("t1_msg1", pop_msg1, 32'h11);
    check("t1_msg2", pop_msg2, 32'h22);
    check("t1_msg3", pop_msg3, 32'h0);
    check("t1_count", 32'(count), 1);
    pop_ready = 1;
    @(posedge clk); #1; pop_ready = 0;
    @(negedge clk);
    check("t1_count_after", 32'(count), 0);
    check("t1_valid_after", 32'(pop_valid), 0);

    // Fill, overflow, drain.
    for (int i = 1; i <= 4; i++) push_one(i, 2'd3);
    @(negedge clk);
    check("t2_full", 32'(full), 1);
    check("t2_ovf_pre", 32'(overflow), 0);
    push_one(5, 2'd3);
    @(negedge clk);
    check("t2_ovf", 32'(overflow), 1);
    check("t2_count", 32'(count), 4);
    @(posedge clk); #1;
    pop_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("t2_drain", pop_data, 32'(i));
    end
    @(posedge clk); #1; pop_ready = 0;
    @(negedge clk);
    check("t2_empty", 32'(count), 0);
    check("t2_ovf_sticky", 32'(overflow), 1);
    pulse_clear();
    @(negedge clk);
    check("t2_ovf_clr", 32'(overflow), 0);

    // Push and pop together on a full FIFO.
    for (int i = 1; i <= 4; i++) push_one(i, 2'd1);
    @(negedge clk);
    check("t3_head", pop_data, 1);
    pop_ready = 1;
    push_one(9, 2'd1);
    pop_ready = 0;
    @(negedge clk);
    check("t3_count", 32'(count), 4);
    check("t3_ovf", 32'(overflow), 0);
    pop_ready = 1;
    check("t3_d0", pop_data, 2);
    @(negedge clk); check("t3_d1", pop_data, 3);
    @(negedge clk); check("t3_d2", pop_data, 4);
    @(negedge clk); check("t3_d3", pop_data, 9);
    @(posedge clk); #1; pop_ready = 0;
    @(negedge clk);
    check("t3_empty", 32'(count), 0);

    // Wrap-around streaming.
    pop_ready = 1;
    for (int i = 0; i < 10; i++) begin
      push_valid = 1; push_len = 0; push_data = i; push_addr = 5'(i);
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_data", pop_data, 32'(i));
      check("t4_count", 32'(count), 1);
    end
    push_valid = 0;
    @(posedge clk); #1; pop_ready = 0;
    @(negedge clk);
    check("t4_empty", 32'(count), 0);

    // Asynchronous reset with entries queued and overflow set.
    for (int i = 0; i < 5; i++) push_one(32'h40 + i, 2'd0);
    for (int i = 0; i < 2; i++) begin
      pop_ready = 1; @(posedge clk); #1; pop_ready = 0;
    end
    @(negedge clk);
    check("t5_pre_count", 32'(count), 2);
    push_one(32'h50, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_count", 32'(count), 0);
    check("t5_rst_valid", 32'(pop_valid), 0);
    check("t5_rst_ovf", 32'(overflow), 0);
    #3 rst_n = 1'b1;

    // Clear beats a simultaneous push and pop.
    push_one(32'h61, 2'd0);
    push_one(32'h62, 2'd0);
    clear = 1; push_valid = 1; push_data = 32'h63; pop_ready = 1;
    @(posedge clk); #1;
    clear = 0; push_valid = 0; pop_ready = 0;
    @(negedge clk);
    check("t6_count", 32'(count), 0);
    check("t6_valid", 32'(pop_valid), 0);

`ifdef IBEX_MSG_FIFO_STATS_EN
    for (int i = 0; i < 6; i++) push_one(32'h70 + i, 2'd0);
    @(negedge clk);
    check("s_drop", 32'(drop_cnt), 2);
    check("s_hwm", 32'(hwm), 4);
    pulse_clear();
    @(negedge clk);
    check("s_drop_clr", 32'(drop_cnt), 0);
    check("s_hwm_clr", 32'(hwm), 0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ibex_msg_fifo.md
Name: ibex_msg_fifo

Overview:
- Buffers outgoing custom messages from one core's message port.
- Each message is output_valid with output_addr, len_o, output_data and msg1..3_data.
- Delivers messages in order to a consumer core's message input: input_valid, input_addr, input_data, len_i, msg1..3_data_i.
- The producing core has no backpressure, so the block absorbs bursts, applies ready-based throttling on delivery, and flags overflow.

Parameters:
- Depth, 4, number of message entries; power of two, >= 2.
- AddrWidth, 5, width of the message address field.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- push_valid_i  input  1  producer message strobe (from core output_valid)
- push_addr_i  input  AddrWidth  message address
- push_len_i  input  2  count of valid extra words (0..3)
- push_data_i  input  32  primary data word
- push_msg1_i  input  32  extra word 1
- push_msg2_i  input  32  extra word 2
- push_msg3_i  input  32  extra word 3
- pop_valid_o  output  1  head message valid (to consumer input_valid)
- pop_ready_i  input  1  consumer accepts head this cycle
- pop_addr_o  output  AddrWidth  head address
- pop_len_o  output  2  head len
- pop_data_o  output  32  head primary word
- pop_msg1_o  output  32  head extra word 1
- pop_msg2_o  output  32  head extra word 2
- pop_msg3_o  output  32  head extra word 3
- clear_i  input  1  synchronous flush; also clears overflow
- count_o  output  $clog2(Depth)+1  occupancy
- full_o  output  1  count_o == Depth
- overflow_o  output  1  sticky: a push was dropped

Behaviour:
- Clock, reset, and entry format:
  - Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
  - Reset (rst_ni low, any cycle, including mid-transfer): pointers and count go to 0, overflow_o=0, pop_valid_o=0, all pop_* data outputs 0.
  - Storage is flushed; entry contents need not be cleared.
  - Entry layout: {addr, len, data, msg1, msg2, msg3}.
- Push:
  - Accepted on a rising clk_i edge when push_valid_i=1 and (count<Depth or pop fires the same cycle).
  - Write pointer increments modulo Depth; wrap-around is natural.
- Pop:
  - Fires when pop_valid_o && pop_ready_i; read pointer advances modulo Depth.
  - pop_valid_o = (count != 0); combinational from registered count.
  - Head fields are read directly from storage at the read pointer.
- Latency: a message pushed at edge N into an empty FIFO shows pop_valid_o=1 in cycle N+1. There is no same-cycle bypass.
- Word masking on output:
  - pop_msgK_o = stored msgK if pop_len_o >= K, else 0.
  - pop_data_o is always driven from the entry.
- Stability: while pop_valid_o && !pop_ready_i, all pop_* outputs hold stable.
- Simultaneous push and pop:
  - count unchanged, both pointers advance.
  - Valid when full: the slot freed by the pop is reused, and no overflow.
- Push into empty with pop_ready_i=1: no pop that cycle (pop_valid_o was 0).
- Overflow: push_valid_i while full and no pop → message dropped, storage untouched, overflow_o set. overflow_o holds until clear_i or reset.
- clear_i:
  - On the next edge: pointers and count go to 0, overflow_o goes to 0.
  - clear_i takes priority over a simultaneous push and pop; both are discarded.
- Ordering: strict FIFO, and no reordering by address.
- count_o arithmetic: +1 on push-only, -1 on pop-only, else unchanged; never exceeds Depth.

Optional Feature:
- Macro: IBEX_MSG_FIFO_STATS_EN.
- When defined, two extra outputs are added:
  - drop_cnt_o [15:0]: increments on every dropped push and saturates at 16'hFFFF.
  - hwm_o [$clog2(Depth):0]: max count_o seen.
- Both reset to 0 on rst_ni and clear to 0 on clear_i.
- When undefined, these ports and their registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Single message into empty FIFO:
  - Stimulus: push addr=5'h03, len=2, data=32'hA5A5_0001, msg1=32'h11, msg2=32'h22, msg3=32'h33; pop_ready_i=0.
  - Response: next cycle pop_valid_o=1, pop_msg1_o=32'h11, pop_msg2_o=32'h22, pop_msg3_o=0, count_o=1.
  - Then assert pop_ready_i=1: count_o=0 and pop_valid_o=0 the following cycle.
- Fill to Depth=4 with data 1..4 and pop_ready_i=0 → full_o=1.
  - Fifth push (data=5) → dropped, overflow_o=1.
  - Drain → data 1,2,3,4 in order, and no 5.
- Full FIFO with push (data=9) and pop in the same cycle:
  - Pop returns 1, count_o stays 4, overflow_o stays 0.
  - Further draining returns 2,3,4,9.
- Wrap-around: 10 push/pop pairs with data 0..9, one per cycle, pop_ready_i=1 → output sequence 0..9, count_o never exceeds 1.
- Reset and clear:
  - Assert rst_ni low asynchronously (between edges) with 3 entries queued → count_o=0, pop_valid_o=0, overflow_o=0 immediately.
  - Separately, clear_i together with a push → count_o=0 next cycle.
- With IBEX_MSG_FIFO_STATS_EN: 6 pushes into Depth=4 with no pops → drop_cnt_o=2, hwm_o=4.
  - clear_i → both read 0.
